// File: rtl/prbs16_checker.sv
// Receiver-side checker for the 16-bit XNOR LFSR stream (taps 16,15,13,4).
// Self-synchronises from received data, then judges bits against a free-running reference.
module prbs16_checker #(
   parameter int LOCK_COUNT  = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int ERR_W       = 16
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             lock_lost
);
   localparam int RUN_W = 8;
   localparam int WIN_W = $clog2(WINDOW + 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t           state;
   state_t           next_state;
   logic [15:0]      hist;
   logic [15:0]      ref_lfsr;
   logic [4:0]       fill;
   logic [RUN_W-1:0] run;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_err;

   logic [15:0]      hist_shift;
   logic             pred_ok;
   logic             exp_bit;
   logic             fill_done;
   logic             sync_hit;
   logic             lk_miss;
   logic             lose;
   logic             win_done;
   logic [RUN_W-1:0] run_inc;
   logic [WIN_W-1:0] win_cnt_inc;
   logic [WIN_W-1:0] win_err_inc;

   function automatic logic lfsr_fb(input logic [15:0] s);
      return ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      hist_shift  = {hist[14:0], bit_in};
      // All-ones history is the generator lock-up pattern: it self-predicts, so never trust it
      pred_ok     = (bit_in == lfsr_fb(hist)) && (hist != 16'hFFFF);
      run_inc     = pred_ok ? run + 1'b1 : '0;
      exp_bit     = lfsr_fb(ref_lfsr);
      win_cnt_inc = win_cnt + 1'b1;
      win_err_inc = win_err + 1'b1;
      fill_done   = (fill == 5'd15);
      sync_hit    = (run_inc == RUN_W'(LOCK_COUNT));
      lk_miss     = (bit_in != exp_bit);
      lose        = lk_miss && (win_err_inc == WIN_W'(LOSS_THRESH));
      win_done    = (win_cnt_inc == WIN_W'(WINDOW));
   end

   always_ff @(posedge CLK) begin
      if (!rst) state <= HUNT;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (bit_valid) begin
         case (state)
            HUNT:    if (fill_done) next_state = SYNC;
            SYNC:    if (sync_hit)  next_state = LOCKED;
            LOCKED:  if (lose)      next_state = HUNT;
            default: next_state = HUNT;
         endcase
      end
   end

   always_comb begin
      locked = (state == LOCKED);
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         hist      <= '0;
         ref_lfsr  <= '0;
         fill      <= '0;
         run       <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
         lock_lost <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (bit_valid) begin
            hist <= hist_shift;
            case (state)
               HUNT: begin
                  fill <= fill + 1'b1;
                  run  <= '0;
               end
               SYNC: begin
                  run <= run_inc;
                  if (sync_hit) begin
                     ref_lfsr <= hist_shift;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end
               end
               LOCKED: begin
                  // Reference is never fed by received data, so a bad bit cannot propagate
                  ref_lfsr <= {ref_lfsr[14:0], exp_bit};
                  if (lose) begin
                     fill    <= '0;
                     win_cnt <= '0;
                     win_err <= '0;
                  end else if (win_done) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt_inc;
                     if (lk_miss) win_err <= win_err_inc;
                  end
                  if (lk_miss) begin
                     err_pulse <= 1'b1;
                     err_count <= sat_inc(err_count);
                  end
               end
               default: ;
            endcase
         end
         if (clear_cnt) begin
            err_count <= '0;
            lock_lost <= 1'b0;
         end
         if (bit_valid && (state == LOCKED) && lose) lock_lost <= 1'b1;
      end
   end
endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the stream judgement.
module tb_prbs16_checker;
   localparam int LOCK_COUNT  = 32;
   localparam int WINDOW      = 64;
   localparam int LOSS_THRESH = 8;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        clear_cnt = 1'b0;
   logic        locked, err_pulse, lock_lost;
   logic [15:0] err_count;
   logic        locked4, err_pulse4, lock_lost4;
   logic [3:0]  err_count4;

   int checks = 0;
   int failures = 0;

   prbs16_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(16)) dut (
      .CLK(CLK), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .lock_lost(lock_lost));

   prbs16_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(4)) dut4 (
      .CLK(CLK), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
      .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .lock_lost(lock_lost4));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: received bits and the reference sequence held as bit queues
   int mst, mfill, mrun, mwcnt, mwerr, mcnt16, mcnt4;
   bit mpulse, mlost;
   bit rx[$];
   bit rq[$];

   function automatic bit predict(input bit q[$]);
      int n = q.size();
      return ~(q[n-16] ^ q[n-15] ^ q[n-13] ^ q[n-4]);
   endfunction

   function automatic bit all_ones(input bit q[$]);
      foreach (q[i]) if (!q[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_rx(input bit b);
      rx.push_back(b);
      if (rx.size() > 16) void'(rx.pop_front());
   endtask

   task automatic model_edge(input bit b, input bit v, input bit clr, input bit rn);
      bit lose;
      bit e;
      lose   = 1'b0;
      mpulse = 1'b0;
      if (!rn) begin
         mst = 0; mfill = 0; mrun = 0; mwcnt = 0; mwerr = 0;
         mcnt16 = 0; mcnt4 = 0; mlost = 1'b0;
         rx.delete(); rq.delete();
         return;
      end
      if (v) begin
         case (mst)
            0: begin
               push_rx(b);
               mfill++;
               if (mfill == 16) begin mst = 1; mrun = 0; end
            end
            1: begin
               if (b == predict(rx) && !all_ones(rx)) mrun++;
               else mrun = 0;
               push_rx(b);
               if (mrun == LOCK_COUNT) begin mst = 2; rq = rx; mwcnt = 0; mwerr = 0; end
            end
            default: begin
               e = predict(rq);
               rq.push_back(e);
               void'(rq.pop_front());
               push_rx(b);
               mwcnt++;
               if (b != e) begin
                  mpulse = 1'b1;
                  if (mcnt16 < 65535) mcnt16++;
                  if (mcnt4 < 15) mcnt4++;
                  mwerr++;
               end
               if (b != e && mwerr == LOSS_THRESH) begin
                  mst = 0; mfill = 0; lose = 1'b1;
               end else if (mwcnt == WINDOW) begin
                  mwcnt = 0; mwerr = 0;
               end
            end
         endcase
      end
      if (clr) begin mcnt16 = 0; mcnt4 = 0; mlost = 1'b0; end
      if (lose) mlost = 1'b1;
   endtask

   // Stimulus sources
   logic [15:0] gen;
   logic [15:0] gen2;
   int vcount, lock_at, npulse;
   bit lock_seen, prev_locked;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic gen_next();
      logic fb;
      fb  = ~(gen[15] ^ gen[14] ^ gen[12] ^ gen[3]);
      gen = {gen[14:0], fb};
      return fb;
   endfunction

   function automatic logic gen2_next();
      logic fb;
      fb   = gen2[15] ^ gen2[13] ^ gen2[12] ^ gen2[10];
      gen2 = {gen2[14:0], fb};
      return fb;
   endfunction

   task automatic step(input logic b, input logic v, input logic clr, input logic rn);
      bit_in = b; bit_valid = v; clear_cnt = clr; rst = rn;
      @(posedge CLK);
      model_edge(b, v, clr, rn);
      if (v && rn) vcount++;
      #1;
      check("locked", int'(locked), int'(mst == 2));
      check("err_pulse", int'(err_pulse), int'(mpulse));
      check("err_count", int'(err_count), mcnt16);
      check("lock_lost", int'(lock_lost), int'(mlost));
      check("locked4", int'(locked4), int'(mst == 2));
      check("err_count4", int'(err_count4), mcnt4);
      if (locked && !prev_locked) lock_at = vcount;
      if (locked) lock_seen = 1'b1;
      if (err_pulse) npulse++;
      prev_locked = locked;
   endtask

   task automatic send(input logic corrupt, input logic clr);
      step(gen_next() ^ corrupt, 1'b1, clr, 1'b1);
   endtask

   task automatic restart();
      gen = 16'h0000;
      repeat (2) step(rb(), rb(), rb(), 1'b0);
      vcount = 0; lock_at = -1; npulse = 0; lock_seen = 1'b0; prev_locked = 1'b0;
   endtask

   initial begin
      int burst;
      logic v, c, clr, rn;

      // Reset with random inputs
      repeat (5) step(rb(), rb(), rb(), 1'b0);
      check("rst_locked", int'(locked), 0);
      check("rst_pulse", int'(err_pulse), 0);
      check("rst_count", int'(err_count), 0);
      check("rst_lost", int'(lock_lost), 0);

      // Clean lock, continuous valid
      restart();
      repeat (1048) send(1'b0, 1'b0);
      check("clean_lock_at", lock_at, 48);
      check("clean_count", int'(err_count), 0);
      check("clean_locked", int'(locked), 1);

      // Clean lock, valid toggling
      restart();
      for (int i = 0; i < 200; i++) begin
         if (i % 2 == 0) step(gen_next(), 1'b1, 1'b0, 1'b1);
         else            step(rb(), 1'b0, 1'b0, 1'b1);
      end
      check("toggle_lock_at", lock_at, 48);

      // Single corrupted bit
      restart();
      for (int i = 1; i <= 400; i++) send(logic'(i == 200), 1'b0);
      check("single_pulses", npulse, 1);
      check("single_count", int'(err_count), 1);
      check("single_locked", int'(locked), 1);

      // Loss of lock and relock
      restart();
      for (int i = 1; i <= 107; i++) send(logic'(i >= 100), 1'b0);
      check("loss_count", int'(err_count), 8);
      check("loss_locked", int'(locked), 0);
      check("loss_lost", int'(lock_lost), 1);
      for (int i = 108; i <= 170; i++) send(1'b0, 1'b0);
      check("relock_at", lock_at, 155);
      check("relock_lost", int'(lock_lost), 1);
      check("relock_locked", int'(locked), 1);
      step(rb(), 1'b1, 1'b0, 1'b0);
      check("midrst_locked", int'(locked), 0);
      check("midrst_pulse", int'(err_pulse), 0);
      check("midrst_count", int'(err_count), 0);
      check("midrst_lost", int'(lock_lost), 0);

      // Lock-up pattern and foreign streams
      restart();
      repeat (500) step(1'b1, 1'b1, 1'b0, 1'b1);
      check("ones_lock_seen", int'(lock_seen), 0);
      check("ones_count", int'(err_count), 0);
      restart();
      gen2 = 16'hACE1;
      repeat (600) step(gen2_next(), 1'b1, 1'b0, 1'b1);
      check("poly_lock_seen", int'(lock_seen), 0);
      check("poly_count", int'(err_count), 0);
      restart();
      repeat (600) step(rb(), 1'b1, 1'b0, 1'b1);
      check("rand_lock_seen", int'(lock_seen), 0);

      // Saturation: 7 mismatches in each of 3 windows
      restart();
      for (int i = 1; i <= 240; i++)
         send(logic'(i > 48 && ((i - 49) % 64) < 35 && ((i - 49) % 5) == 0), 1'b0);
      check("sat_count4", int'(err_count4), 15);
      check("sat_count16", int'(err_count), 21);
      check("sat_locked4", int'(locked4), 1);
      for (int i = 241; i <= 250; i++) begin
         send(logic'(i == 245), logic'(i == 245));
         if (i == 245) begin
            check("clr_pulse", int'(err_pulse), 1);
            check("clr_count", int'(err_count), 0);
         end
      end

      // Randomized traffic with bursts, clears and occasional resets
      restart();
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         v   = logic'($urandom_range(0, 3) != 0);
         rn  = logic'($urandom_range(0, 1499) != 0);
         clr = logic'($urandom_range(0, 99) == 0);
         if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(4, 12);
         c = logic'(burst > 0 || $urandom_range(0, 59) == 0);
         if (v) begin
            if (burst > 0) burst--;
            step(gen_next() ^ c, 1'b1, clr, rn);
         end else begin
            step(rb(), 1'b0, clr, rn);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
Serial receiver-side checker for the 16-bit XNOR LFSR pseudo-random stream produced on chip. Sits downstream of the generator, or on a loop-back input, and judges whether an incoming bit stream is a valid sequence of that generator. It self-synchronises to the stream, declares lock, then counts bit errors and declares loss of lock when errors exceed a threshold.

Parameters:
LOCK_COUNT, 32, consecutive correct predictions required in SYNC before declaring lock (range 1..255)
WINDOW, 64, valid-bit length of the error-density window used while locked (range 2..256)
LOSS_THRESH, 8, mismatches within one window that force loss of lock (range 1..WINDOW)
ERR_W, 16, width of the saturating error counter

Ports:
CLK  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-low reset
bit_in  in  1  received stream bit
bit_valid  in  1  bit_in is sampled only in cycles where this is high
clear_cnt  in  1  synchronous clear of err_count and lock_lost
locked  out  1  high while in LOCKED
err_pulse  out  1  one-cycle pulse for each mismatch detected while LOCKED
err_count  out  ERR_W  saturating count of mismatches while LOCKED
lock_lost  out  1  sticky; set on every LOCKED->HUNT transition

Behaviour:
- Stream definition: each generator step emits its feedback bit fb = ~(s[15]^s[14]^s[12]^s[3]), where s is its state before the shift; the new state is {s[14:0], fb}.
- hist[15:0]: shift register of the last 16 received valid bits (newest in [0]). Predicted bit = ~(hist[15]^hist[14]^hist[12]^hist[3]).
- Reset (rst=0 at a clock edge): state=HUNT; hist, fill, run, ref, win_cnt, win_err = 0; locked=0, err_pulse=0, err_count=0, lock_lost=0. Reset mid-operation behaves identically and has priority over every other input.
- No internal state changes in a cycle with bit_valid=0 (err_pulse=0).
- HUNT: each valid bit shifts into hist and increments fill. On the 16th bit, go to SYNC with run=0.
- SYNC: each valid bit is compared with the prediction from hist before the shift, then shifted in.
  - Match and hist != 16'hFFFF: run++.
  - Mismatch, or hist == 16'hFFFF (generator lock-up pattern): run=0.
  - When run reaches LOCK_COUNT: go to LOCKED; ref <= hist after the shift; win_cnt=0; win_err=0.
- LOCKED: ref free-runs independently of received data. Per valid bit: exp = ~(ref[15]^ref[14]^ref[12]^ref[3]); ref <= {ref[14:0], exp}; hist still shifts bit_in; win_cnt++.
  - Mismatch (bit_in != exp): err_pulse=1 in the next cycle; err_count++, saturating at all-ones; win_err++.
  - If win_err reaches LOSS_THRESH: go to HUNT, fill=0, lock_lost=1, locked=0.
  - Otherwise, when win_cnt completes WINDOW bits: win_cnt=0, win_err=0.
- A single corrupted bit while LOCKED gives exactly one err_pulse. No error propagation occurs, because ref is not fed by received data.
- Latency: locked, err_pulse, err_count and lock_lost are registered and update in the cycle after the edge that sampled the deciding bit.
- clear_cnt=1: err_count=0 and lock_lost=0. Lock state is not affected.
  - clear_cnt together with a mismatch: err_count=0, and err_pulse still asserts.
  - clear_cnt together with a loss-of-lock event: lock_lost=1 (set wins).
- err_count counts only LOCKED mismatches. SYNC mismatches are not counted.

Test Plan:
- Reset check: hold rst=0 with random bit_in/bit_valid for 5 cycles -> locked=0, err_pulse=0, err_count=0, lock_lost=0.
- Clean lock: feed a generator model seeded at 16'h0000, bit_valid=1 continuously -> locked rises exactly one cycle after valid bit 48 (16 fill + 32 matches); err_count stays 0 for 1000 further bits. Repeat with bit_valid toggling 1/0 -> lock at valid bit 48, with no advance on idle cycles.
- Single error: after lock, invert stream bit 200 -> exactly one err_pulse; err_count=1; locked stays 1; no further pulses.
- Loss of lock: after lock, invert 8 consecutive bits -> err_count=8, locked=0 and lock_lost=1 one cycle after the 8th; with a clean stream continuing, relock one cycle after 48 further valid bits, and lock_lost remains 1.
- Lock-up and garbage: a constant-1 stream for 500 bits, and a stream from a different polynomial -> locked never asserts; err_count=0.
- Counter edges: ERR_W=4 with 7 mismatches per 64-bit window for 3 windows -> err_count saturates at 15 and locked stays 1. clear_cnt asserted in the same cycle as a mismatch -> err_count=0 and err_pulse=1. rst=0 while LOCKED -> all outputs 0 next cycle.
